// File: rtl/local_memory_arbiter_if.sv
// local_memory_arbiter_if: two requester ports plus the shared single-port memory bus.
interface local_memory_arbiter_if #(parameter int SIZE_ADDR = 8);
  logic req0_valid, req0_ready, req0_we, req0_lock, req0_rvalid;
  logic [SIZE_ADDR-1:0] req0_addr;
  logic [31:0] req0_wdata, req0_rdata;
  logic req1_valid, req1_ready, req1_we, req1_lock, req1_rvalid;
  logic [SIZE_ADDR-1:0] req1_addr;
  logic [31:0] req1_wdata, req1_rdata;
  logic mem_ce, mem_rden, mem_wren;
  logic [SIZE_ADDR-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata, mem_rdata,
    input  req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
    input  mem_ce, mem_rden, mem_wren, mem_addr, mem_wdata
  );
  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata, mem_rdata,
    output req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
    output mem_ce, mem_rden, mem_wren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/local_memory_arbiter.sv
// local_memory_arbiter: round-robin two-requester arbiter with locked bursts onto one memory port.
module local_memory_arbiter #(
  parameter int SIZE_ADDR = 8,
  parameter int MAX_BURST = 16
) (
  input logic aclk,
  input logic aresetn,
  local_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [8:0] MAX = 9'(MAX_BURST);
  state_t state_q, state_d;
  logic rr_q, rr_d, rv0_q, rv1_q;
  logic [8:0] cnt_q, cnt_d, cnt_nx;
  logic g0, g1, acc0, acc1, acc, own, we, lock, other_v, busy, rel;
  logic [SIZE_ADDR-1:0] addr;
  logic [31:0] wdata;
  always_comb begin
    g0 = aresetn && (state_q == OWN0 || (state_q == IDLE && bus.req0_valid && (!bus.req1_valid || rr_q)));
    g1 = aresetn && (state_q == OWN1 || (state_q == IDLE && bus.req1_valid && (!bus.req0_valid || !rr_q)));
    acc0 = g0 && bus.req0_valid;
    acc1 = g1 && bus.req1_valid;
    acc = acc0 || acc1;
    own = acc ? acc1 : state_q == OWN1;
    we = acc1 ? bus.req1_we : bus.req0_we;
    lock = own ? bus.req1_lock : bus.req0_lock;
    other_v = own ? bus.req0_valid : bus.req1_valid;
    cnt_nx = (acc && cnt_q < MAX) ? cnt_q + 9'd1 : cnt_q;
    // a full burst yields in the same cycle as its last beat, so the hand-over has no bubble
    busy = acc || state_q != IDLE;
    rel = busy && ((acc && !lock) || (cnt_nx >= MAX && other_v));
    state_d = (!busy || rel) ? IDLE : own ? OWN1 : OWN0;
    rr_d = rel ? own : rr_q;
    cnt_d = (!busy || rel) ? 9'd0 : cnt_nx;
    addr = acc1 ? bus.req1_addr : acc0 ? bus.req0_addr : '0;
    wdata = acc1 ? bus.req1_wdata : acc0 ? bus.req0_wdata : '0;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      rr_q <= 1'b1;
      cnt_q <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      rv0_q <= acc0 && !bus.req0_we;
      rv1_q <= acc1 && !bus.req1_we;
    end
  end
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.req0_rvalid = rv0_q && aresetn;
  assign bus.req1_rvalid = rv1_q && aresetn;
  assign bus.req0_rdata = bus.mem_rdata;
  assign bus.req1_rdata = bus.mem_rdata;
  assign bus.mem_ce = acc;
  assign bus.mem_wren = acc && we;
  assign bus.mem_rden = acc && !we;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = wdata;
endmodule

// File: tb/tb_local_memory_arbiter.sv
// tb_local_memory_arbiter: directed per-cycle vectors with a scoreboard of expected accepts and read returns.
module tb_local_memory_arbiter;
  localparam logic [2:0] N = 3'b000, R = 3'b100, W = 3'b101, RL = 3'b110, WL = 3'b111;
  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0] acc;
    logic ce, we, rd;
    logic [7:0] addr;
    logic [31:0] wd;
  } acc_t;
  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0] rv;
    logic [31:0] data;
  } rd_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic expect_rd = 1'b1;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  acc_t acc_q[$];
  rd_t rd_q[$];

  local_memory_arbiter_if #(.SIZE_ADDR(8)) bus ();
  local_memory_arbiter #(.SIZE_ADDR(8), .MAX_BURST(4)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    if (bus.mem_ce && bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_ce && bus.mem_rden) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic step(input logic [2:0] c0, input logic [7:0] a0, input logic [31:0] d0,
                      input logic [2:0] c1, input logic [7:0] a1, input logic [31:0] d1, input int e);
    acc_t x;
    rd_t r;
    @(posedge aclk);
    #1;
    {bus.req0_valid, bus.req0_lock, bus.req0_we} = c0;
    bus.req0_addr = a0;
    bus.req0_wdata = d0;
    {bus.req1_valid, bus.req1_lock, bus.req1_we} = c1;
    bus.req1_addr = a1;
    bus.req1_wdata = d1;
    if (e >= 0) begin
      x.cyc = cyc;
      x.acc = (e == 1) ? 2'b10 : 2'b01;
      x.ce = 1'b1;
      x.we = (e == 1) ? c1[0] : c0[0];
      x.rd = !x.we;
      x.addr = (e == 1) ? a1 : a0;
      x.wd = (e == 1) ? d1 : d0;
      acc_q.push_back(x);
      if (x.we) ref_mem[x.addr] = x.wd;
      else if (expect_rd) begin
        r.cyc = cyc + 1;
        r.rv = x.acc;
        r.data = ref_mem[x.addr];
        rd_q.push_back(r);
      end
    end
  endtask

  always @(negedge aclk) begin
    acc_t g, x;
    rd_t rg, rx;
    if (!aresetn) begin
      checks++;
      if (bus.req0_ready || bus.req1_ready || bus.mem_ce || bus.mem_rden || bus.mem_wren ||
          bus.req0_rvalid || bus.req1_rvalid) begin
        errors++;
        $display("FAIL reset_quiet cyc=%0d ready=%b%b ce=%b rden=%b wren=%b rvalid=%b%b, required all 0",
                 cyc, bus.req1_ready, bus.req0_ready, bus.mem_ce, bus.mem_rden, bus.mem_wren,
                 bus.req1_rvalid, bus.req0_rvalid);
      end
    end
    g.cyc = cyc;
    g.acc = {bus.req1_valid && bus.req1_ready, bus.req0_valid && bus.req0_ready};
    g.ce = bus.mem_ce;
    g.we = bus.mem_wren;
    g.rd = bus.mem_rden;
    g.addr = bus.mem_addr;
    g.wd = bus.mem_wdata;
    if (g.acc != 2'b00 || g.ce) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL accept cyc=%0d unexpected acc=%b ce=%b addr=%h", cyc, g.acc, g.ce, g.addr);
      end else begin
        x = acc_q.pop_front();
        if (g != x) begin
          errors++;
          $display("FAIL accept got cyc=%0d acc=%b ce=%b we=%b rd=%b addr=%h wd=%h, required cyc=%0d acc=%b ce=%b we=%b rd=%b addr=%h wd=%h",
                   g.cyc, g.acc, g.ce, g.we, g.rd, g.addr, g.wd, x.cyc, x.acc, x.ce, x.we, x.rd, x.addr, x.wd);
        end
      end
    end
    rg.cyc = cyc;
    rg.rv = {bus.req1_rvalid, bus.req0_rvalid};
    rg.data = bus.req1_rvalid ? bus.req1_rdata : bus.req0_rdata;
    if (rg.rv != 2'b00) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid cyc=%0d unexpected rvalid=%b data=%h", cyc, rg.rv, rg.data);
      end else begin
        rx = rd_q.pop_front();
        if (rg != rx) begin
          errors++;
          $display("FAIL rvalid got cyc=%0d rvalid=%b data=%h, required cyc=%0d rvalid=%b data=%h",
                   rg.cyc, rg.rv, rg.data, rx.cyc, rx.rv, rx.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d, required stimulus to complete", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    {bus.req0_valid, bus.req0_lock, bus.req0_we, bus.req1_valid, bus.req1_lock, bus.req1_we} = '0;
    bus.req0_addr = '0;
    bus.req1_addr = '0;
    bus.req0_wdata = '0;
    bus.req1_wdata = '0;
    step(R, 8'h01, 0, R, 8'h02, 0, -1);
    step(W, 8'h01, 1, W, 8'h02, 2, -1);
    step(N, 0, 0, N, 0, 0, -1);
    aresetn = 1'b1;
    // round-robin contention straight out of reset
    step(W, 8'h10, 32'hA0, W, 8'h20, 32'hB0, 0);
    step(W, 8'h11, 32'hA1, W, 8'h20, 32'hB0, 1);
    step(R, 8'h10, 0, R, 8'h21, 0, 0);
    step(R, 8'h10, 0, R, 8'h20, 0, 1);
    // write then immediate read of the same address
    step(W, 8'h05, 32'hDEADBEEF, N, 0, 0, 0);
    step(R, 8'h05, 0, N, 0, 0, 0);
    step(N, 0, 0, R, 8'h20, 0, 1);
    // lock: three locked beats then an unlocked one
    step(WL, 8'h30, 32'h30, R, 8'h20, 0, 0);
    step(WL, 8'h31, 32'h31, R, 8'h20, 0, 0);
    step(WL, 8'h32, 32'h32, R, 8'h20, 0, 0);
    step(W, 8'h33, 32'h33, R, 8'h20, 0, 0);
    step(R, 8'h30, 0, R, 8'h20, 0, 1);
    // burst cap with the other requester waiting
    step(WL, 8'h40, 32'h40, R, 8'h20, 0, 0);
    step(WL, 8'h41, 32'h41, R, 8'h20, 0, 0);
    step(WL, 8'h42, 32'h42, R, 8'h20, 0, 0);
    step(WL, 8'h43, 32'h43, R, 8'h20, 0, 0);
    step(WL, 8'h44, 32'h44, R, 8'h20, 0, 1);
    // counter saturates while the other side is idle
    step(WL, 8'h50, 32'h50, N, 0, 0, 0);
    step(WL, 8'h51, 32'h51, N, 0, 0, 0);
    step(WL, 8'h52, 32'h52, N, 0, 0, 0);
    step(WL, 8'h53, 32'h53, N, 0, 0, 0);
    step(WL, 8'h54, 32'h54, N, 0, 0, 0);
    step(RL, 8'h54, 0, R, 8'h43, 0, 0);
    step(R, 8'h50, 0, R, 8'h43, 0, 1);
    // lock held across a valid gap
    step(WL, 8'h60, 32'h60, R, 8'h20, 0, 0);
    step(N, 0, 0, R, 8'h20, 0, -1);
    step(N, 0, 0, R, 8'h20, 0, -1);
    step(N, 0, 0, R, 8'h20, 0, -1);
    step(W, 8'h61, 32'h61, R, 8'h20, 0, 0);
    step(N, 0, 0, R, 8'h60, 0, 1);
    // reset right after an accepted read
    expect_rd = 1'b0;
    step(N, 0, 0, R, 8'h20, 0, 1);
    expect_rd = 1'b1;
    step(N, 0, 0, N, 0, 0, -1);
    aresetn = 1'b0;
    step(R, 8'h05, 0, R, 8'h20, 0, -1);
    step(R, 8'h05, 0, R, 8'h20, 0, 0);
    aresetn = 1'b1;
    step(R, 8'h05, 0, R, 8'h20, 0, 1);
    step(N, 0, 0, N, 0, 0, -1);
    step(N, 0, 0, N, 0, 0, -1);
    step(N, 0, 0, N, 0, 0, -1);
    checks++;
    if (acc_q.size() != 0) begin
      errors++;
      $display("FAIL accept_drain pending=%0d, required 0", acc_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rvalid_drain pending=%0d, required 0", rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
